// File: rtl/reg_change_monitor_pkg.sv
// Shared definitions for the register change monitor: record layout helpers and limits.
package reg_change_monitor_pkg;

    localparam logic [7:0] OVF_MAX = 8'hFF;

    // Packed record is {ts, x, y, z}; z occupies the least significant bits.
    function automatic int rec_w(input int ts_width, input int width);
        return ts_width + 3 * width;
    endfunction

    function automatic int z_lsb(input int width);
        return 0 * width;
    endfunction

    function automatic int y_lsb(input int width);
        return 1 * width;
    endfunction

    function automatic int x_lsb(input int width);
        return 2 * width;
    endfunction

    function automatic int ts_lsb(input int width);
        return 3 * width;
    endfunction

endpackage

// File: rtl/reg_change_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on dout while not empty.
module reg_change_monitor_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Storage is never reset, so the head is masked while empty.
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/reg_change_monitor.sv
// On-chip trace recorder: logs timestamped changes of x/y/z into a FIFO drained by valid/ready.
module reg_change_monitor
    import reg_change_monitor_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         x,
    input  logic [WIDTH-1:0]         y,
    input  logic [WIDTH-1:0]         z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [WIDTH-1:0]         out_x,
    output logic [WIDTH-1:0]         out_y,
    output logic [WIDTH-1:0]         out_z,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               overflow_cnt
);

    localparam int REC_W = rec_w(TS_WIDTH, WIDTH);

    // Output handshake: a record transfers on any edge where out_valid and out_ready are both 1;
    // out_valid never depends on out_ready.
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    prev_x;
    logic [WIDTH-1:0]    prev_y;
    logic [WIDTH-1:0]    prev_z;
    logic                arm;

    logic                event_hit;
    logic                push;
    logic                pop;
    logic                drop;
    logic                full;
    logic                empty;
    logic [REC_W-1:0]    rec_in;
    logic [REC_W-1:0]    rec_out;

    assign event_hit = en && (arm || (x != prev_x) || (y != prev_y) || (z != prev_z));
    assign pop       = !empty && out_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push      = event_hit && (!full || pop);
    assign drop      = event_hit && !push;
    assign rec_in    = {ts, x, y, z};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts           <= '0;
            prev_x       <= '0;
            prev_y       <= '0;
            prev_z       <= '0;
            arm          <= 1'b1;
            overflow_cnt <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            if (en) begin
                prev_x <= x;
                prev_y <= y;
                prev_z <= z;
                arm    <= 1'b0;
            end
            if (drop && overflow_cnt != OVF_MAX) overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    reg_change_monitor_sync_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_valid = !empty;
    assign out_ts    = rec_out[ts_lsb(WIDTH) +: TS_WIDTH];
    assign out_x     = rec_out[x_lsb(WIDTH)  +: WIDTH];
    assign out_y     = rec_out[y_lsb(WIDTH)  +: WIDTH];
    assign out_z     = rec_out[z_lsb(WIDTH)  +: WIDTH];

endmodule

// File: tb/tb_reg_change_monitor.sv
// Scoreboard bench for reg_change_monitor: driver pushes expected records, a negedge monitor pops them.
module tb_reg_change_monitor;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int TS_W  = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int REC_W = TS_W + 3 * W;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [W-1:0]      x, y, z;
    logic              out_valid;
    logic              out_ready;
    logic [TS_W-1:0]   out_ts;
    logic [W-1:0]      out_x, out_y, out_z;
    logic [CNT_W-1:0]  count;
    logic [7:0]        overflow_cnt;

    reg_change_monitor #(
        .WIDTH    (W),
        .DEPTH    (DEPTH),
        .TS_WIDTH (TS_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .x            (x),
        .y            (y),
        .z            (z),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ts       (out_ts),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_z        (out_z),
        .count        (count),
        .overflow_cnt (overflow_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [REC_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_err    = 0;
    bit               chk_en   = 0;

    // Reference model of the observable state
    logic [31:0]      cyc;
    int               m_cnt;
    int               m_ovf;
    bit               m_arm;
    logic [W-1:0]     m_px, m_py, m_pz;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc   = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_arm = 1;
        m_px  = '0;
        m_py  = '0;
        m_pz  = '0;
        exp_q.delete();
    endtask

    // One clock cycle: inputs already applied; model the edge, then advance.
    task automatic tick();
        bit               ev, pop, push;
        logic [REC_W-1:0] rec;
        ev   = en && (m_arm || x != m_px || y != m_py || z != m_pz);
        pop  = (m_cnt != 0) && out_ready;
        push = ev && (m_cnt < DEPTH || pop);
        rec  = {cyc[TS_W-1:0], x, y, z};
        if (en) begin
            m_arm = 0;
            m_px  = x;
            m_py  = y;
            m_pz  = z;
        end
        @(posedge clk);
        #1;
        if (push) exp_q.push_back(rec);
        if (ev && !push && m_ovf != 255) m_ovf++;
        m_cnt = m_cnt + int'(push) - int'(pop);
        cyc++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1;
    endtask

    // Monitor: compares the presented head whenever it is consumed
    always @(negedge clk) begin
        logic [REC_W-1:0] e;
        if (chk_en) begin
            check("count", 128'(count), 128'(m_cnt));
            check("overflow_cnt", 128'(overflow_cnt), 128'(m_ovf));
            check("out_valid", 128'(out_valid), 128'(m_cnt != 0));
            if (!out_valid) begin
                check("idle_zero", 128'({out_ts, out_x, out_y, out_z}), 128'(0));
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", 128'({out_ts, out_x, out_y, out_z}), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("record", 128'({out_ts, out_x, out_y, out_z}), 128'(e));
                end
            end
        end
    end

    initial begin
        logic [31:0] t0;
        rst_n     = 1'b0;
        en        = 1'b0;
        x         = '0;
        y         = '0;
        z         = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_count", 128'(count), 128'(0));

        // Test 1: constant zero inputs log exactly one record at ts 0
        release_reset();
        en = 1'b1;
        repeat (20) tick();
        check("t1_count", 128'(count), 128'(1));
        check("t1_head", 128'({out_valid, out_ts, out_x}), 128'({1'b1, 4'd0, 32'd0}));

        // Test 2: single-register changes, records drained as they arrive
        out_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 35; i++) begin
            if (cyc == t0 + 10) x = 32'd5;
            if (cyc == t0 + 20) y = 32'd6;
            if (cyc == t0 + 30) z = 32'd7;
            tick();
            if (cyc == t0 + 11) check("t2_x_latency", 128'({out_valid, out_x, out_y}), 128'({1'b1, 32'd5, 32'd0}));
        end

        // Test 3: 12 back-to-back changes into an 8-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            x = x + 32'd1;
            tick();
        end
        check("t3_count", 128'(count), 128'(8));
        check("t3_ovf", 128'(overflow_cnt), 128'(4));
        check("t3_head", 128'(out_x), 128'(6));

        // Test 4: full FIFO, pop and change on the same edge
        out_ready = 1'b1;
        x = 32'd18;
        tick();
        check("t4_count", 128'(count), 128'(8));
        check("t4_ovf", 128'(overflow_cnt), 128'(4));
        check("t4_head", 128'(out_x), 128'(7));
        repeat (10) tick();

        // Disabled observation ignores changes; re-enable logs against held prev values
        en = 1'b0;
        x  = 32'd99;
        repeat (3) tick();
        check("en0_count", 128'(count), 128'(0));
        en = 1'b1;
        repeat (3) tick();

        // Test 6: reset asserted mid-cycle with records queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 32'd100 + 32'(i);
            tick();
        end
        check("t6_count_before", 128'(count), 128'(5));
        #2;
        chk_en = 0;
        rst_n  = 1'b0;
        #1;
        check("t6_valid_drop", 128'(out_valid), 128'(0));
        check("t6_out_zero", 128'({out_ts, out_x, out_y, out_z}), 128'(0));
        check("t6_ovf_clear", 128'(overflow_cnt), 128'(0));
        release_reset();
        repeat (3) tick();
        check("t6_rearm_count", 128'(count), 128'(1));
        check("t6_rearm_head", 128'({out_ts, out_x, out_y, out_z}), 128'({4'd0, 32'd104, 32'd6, 32'd7}));

        // Test 5: timestamp wraps at 2**TS_W
        out_ready = 1'b1;
        while (cyc < 22) begin
            if (cyc == 15) x = 32'd200;
            if (cyc == 17) x = 32'd201;
            tick();
            if (cyc == 16) check("t5_ts15", 128'({out_valid, out_ts}), 128'({1'b1, 4'd15}));
            if (cyc == 18) check("t5_ts1", 128'({out_valid, out_ts}), 128'({1'b1, 4'd1}));
        end

        @(negedge clk);
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
